// File: rtl/ext_pipe.sv
// Registered immediate / load-data extender with a 2-entry output FIFO.
// It flags misaligned halfword loads and keeps a saturating count of them.
module ext_pipe #(
    parameter  int DATA_W = 32,
    parameter  int IMM_W  = 16,
    parameter  int CNT_W  = 8,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [2:0] {
        OP_ZEXT = 3'd0,
        OP_SEXT = 3'd1,
        OP_LUI  = 3'd2,
        OP_LBU  = 3'd3,
        OP_LB   = 3'd4,
        OP_LHU  = 3'd5,
        OP_LH   = 3'd6,
        OP_BOFS = 3'd7
    } op_e;

    op_e               op;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_sext;
    logic [15:0]       lane_h;
    logic [7:0]        lane_b;
    logic              misaligned;
    logic [DATA_W-1:0] res_data;

    logic [DATA_W-1:0] ent_data [2];
    logic              ent_err  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    // ------------------------------------------------------------------
    // Extension datapath
    // ------------------------------------------------------------------
    assign op       = op_e'(in_op);
    assign imm      = in_data[IMM_W-1:0];
    assign imm_sext = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};

    // Little-endian lane pick: shift the addressed byte down to bit 0.
    assign lane_h = 16'(in_data >> {in_off, 3'b000});
    assign lane_b = lane_h[7:0];

    assign misaligned = ((op == OP_LH) || (op == OP_LHU)) && in_off[0];

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // res_data unassigned, which would otherwise infer a latch.
        res_data = '0;
        case (op)
            OP_ZEXT: res_data = DATA_W'(imm);
            OP_SEXT: res_data = imm_sext;
            OP_LUI:  res_data = {imm, {(DATA_W - IMM_W){1'b0}}};
            OP_LBU:  res_data = DATA_W'(lane_b);
            OP_LB:   res_data = {{(DATA_W - 8){lane_b[7]}}, lane_b};
            OP_LHU:  res_data = misaligned ? '0 : DATA_W'(lane_h);
            OP_LH:   res_data = misaligned ? '0 : {{(DATA_W - 16){lane_h[15]}}, lane_h};
            OP_BOFS: res_data = {imm_sext[DATA_W-3:0], 2'b00};
            default: res_data = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and FIFO control
    // ------------------------------------------------------------------
    // Ready depends only on occupancy, never on out_ready.
    assign in_ready  = (count != 2'd2) && !flush;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    assign out_data = ent_data[rd_ptr];
    assign out_err  = ent_err[rd_ptr];

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; flush only moves pointers, stale data is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: storage is cleared on reset because the head entry is
            // visible on out_data/out_err even while out_valid is low.
            for (int i = 0; i < 2; i++) begin
                ent_data[i] <= '0;
                ent_err[i]  <= 1'b0;
            end
        end else if (push && !flush) begin
            ent_data[wr_ptr] <= res_data;
            ent_err[wr_ptr]  <= misaligned;
        end
    end

    // Counts at acceptance; a later flush does not undo the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (push && misaligned && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: an arithmetic reference model feeds an expected
// queue, and an independent monitor checks each result the DUT presents.
module tb_ext_pipe;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int CNT_W  = 2;
    localparam int OFF_W  = 2;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_data;
    logic [OFF_W-1:0]  in_off;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic [CNT_W-1:0]  err_cnt;

    ext_pipe #(
        .DATA_W(DATA_W),
        .IMM_W (IMM_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_data  (in_data),
        .in_off   (in_off),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } res_t;

    res_t exp_q[$];
    int   total     = 0;
    int   bad       = 0;
    int   model_err = 0;
    bit   mon_en    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: no response within cycle budget at %0t", name, $time);
    endtask

    // Reference model: plain integer arithmetic on the mode rules.
    function automatic res_t model(input logic [2:0] op, input logic [31:0] data, input int off);
        longint imm, simm, b, h, v;
        res_t   r;
        r.err = 1'b0;
        imm   = longint'(data & 32'hFFFF);
        simm  = (imm >= 32768) ? imm - 65536 : imm;
        b     = longint'((data >> (8 * off)) & 32'hFF);
        h     = longint'((data >> (8 * off)) & 32'hFFFF);
        case (op)
            3'd0: v = imm;
            3'd1: v = simm;
            3'd2: v = imm * 65536;
            3'd3: v = b;
            3'd4: v = (b >= 128) ? b - 256 : b;
            3'd5, 3'd6: begin
                if (off % 2 == 1) begin
                    v     = 0;
                    r.err = 1'b1;
                end else begin
                    v = (op == 3'd6 && h >= 32768) ? h - 65536 : h;
                end
            end
            default: v = simm * 4;
        endcase
        r.data = v[31:0];
        return r;
    endfunction

    // Scoreboard feed: sample the request mid-cycle, commit on the edge.
    always begin : sb_push
        res_t e;
        bit   take;
        bit   rst_s;
        bit   fl_s;
        @(negedge clk);
        take  = (in_valid === 1'b1) && (in_ready === 1'b1) && (reset !== 1'b1);
        rst_s = (reset === 1'b1);
        fl_s  = (flush === 1'b1);
        e     = model(in_op, in_data, int'(in_off));
        @(posedge clk);
        if (rst_s) begin
            exp_q.delete();
            model_err = 0;
        end else if (fl_s) begin
            exp_q.delete();
        end else if (take) begin
            exp_q.push_back(e);
            if (e.err && model_err < ERR_MAX) model_err++;
        end
    end

    // Monitor: checks handshake state and pops/compares delivered results.
    always @(negedge clk) begin : monitor
        res_t r;
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) && (flush !== 1'b1)));
            check("err_cnt", 32'(err_cnt), 32'(model_err));
            if (out_valid === 1'b1 && exp_q.size() > 0) begin
                if (out_ready === 1'b1) begin
                    r = exp_q.pop_front();
                    check("out_data", out_data, r.data);
                    check("out_err", 32'(out_err), 32'(r.err));
                end else begin
                    check("stall_data", out_data, exp_q[0].data);
                    check("stall_err", 32'(out_err), 32'(exp_q[0].err));
                end
            end
        end
    end

    // Present a request and hold it until accepted; returns just after that edge.
    task automatic send(input logic [2:0] op, input logic [31:0] data, input logic [1:0] off);
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        in_off   = off;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                timeout_fail("send_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Directed vector with fixed expected values, checked one cycle after accept.
    task automatic send_expect(input string name, input logic [2:0] op, input logic [31:0] data,
                               input logic [1:0] off, input logic [31:0] exp_d, input logic exp_e);
        send(op, data, off);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"}, out_data, exp_d);
        check({name, "_err"}, 32'(out_err), 32'(exp_e));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((out_valid === 1'b1) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_valid === 1'b1) timeout_fail("drain");
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] lb_exp  [4] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    logic [31:0] lbu_exp [4] = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};

    initial begin : stim
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_data   = '0;
        in_off    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        @(negedge clk);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;

        // Immediate modes; upper bits of in_data must be ignored.
        send_expect("zext", 3'd0, 32'hA5A58001, 2'd0, 32'h00008001, 1'b0);
        send_expect("sext", 3'd1, 32'hA5A58001, 2'd1, 32'hFFFF8001, 1'b0);
        send_expect("lui",  3'd2, 32'hA5A58001, 2'd2, 32'h80010000, 1'b0);
        send_expect("bofs", 3'd7, 32'hA5A58001, 2'd3, 32'hFFFE0004, 1'b0);

        for (int k = 0; k < 4; k++) begin
            send_expect("lb",  3'd4, 32'h80FF7F01, 2'(k), lb_exp[k],  1'b0);
            send_expect("lbu", 3'd3, 32'h80FF7F01, 2'(k), lbu_exp[k], 1'b0);
        end

        send_expect("lh_off0",  3'd6, 32'h80007FFF, 2'd0, 32'h00007FFF, 1'b0);
        send_expect("lhu_off0", 3'd5, 32'h80007FFF, 2'd0, 32'h00007FFF, 1'b0);
        send_expect("lh_off2",  3'd6, 32'h80007FFF, 2'd2, 32'hFFFF8000, 1'b0);
        send_expect("lhu_off2", 3'd5, 32'h80007FFF, 2'd2, 32'h00008000, 1'b0);
        send_expect("lh_off1",  3'd6, 32'h80007FFF, 2'd1, 32'h00000000, 1'b1);
        check("err_cnt_one", 32'(err_cnt), 32'd1);

        // Four more misaligned requests (five total) saturate the 2-bit counter.
        send_expect("lhu_off1", 3'd5, 32'h80007FFF, 2'd1, 32'h00000000, 1'b1);
        send_expect("lh_off3",  3'd6, 32'h12345678, 2'd3, 32'h00000000, 1'b1);
        send_expect("lhu_off3", 3'd5, 32'h12345678, 2'd3, 32'h00000000, 1'b1);
        send_expect("lh_off1b", 3'd6, 32'hFFFFFFFF, 2'd1, 32'h00000000, 1'b1);
        check("err_cnt_sat", 32'(err_cnt), 32'd3);

        // Backpressure: three back-to-back requests against a stalled consumer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_data   = 32'h0000AAAA;
        in_off    = 2'd0;
        @(posedge clk);
        #1;
        in_op   = 3'd4;
        in_data = 32'h00000080;
        @(posedge clk);
        #1;
        in_op   = 3'd7;
        in_data = 32'h00000003;
        @(negedge clk);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_still_held", 32'(in_ready), 32'd0);
        check("bp_head", out_data, 32'h0000AAAA);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'd7, 32'h00000003, 2'd0);
        drain();

        // Flush with two buffered entries and a request on the input.
        out_ready = 1'b0;
        send(3'd1, 32'h00001234, 2'd0);
        send(3'd2, 32'h00005678, 2'd0);
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_data  = 32'h00009999;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset with one buffered entry, err_cnt=2, flush and a pending request.
        pulse_reset();
        send(3'd6, 32'h00000000, 2'd1);
        send(3'd5, 32'h00000000, 2'd3);
        drain();
        check("pre_rst_err_cnt", 32'(err_cnt), 32'd2);
        out_ready = 1'b0;
        send(3'd1, 32'h0000FFFF, 2'd0);
        reset    = 1'b1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'd2;
        in_data  = 32'h00004321;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_data", out_data, 32'h0);
        check("mrst_err", 32'(out_err), 32'd0);
        check("mrst_err_cnt", 32'(err_cnt), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Randomised traffic with random backpressure and occasional flush.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_op     = 3'($urandom);
            in_data   = $urandom;
            in_off    = 2'($urandom);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(39) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        drain();
        @(negedge clk);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
